// File: rtl/pattern_det_if.sv
// Serial frame input and decoded result signals of pattern_det.
interface pattern_det_if #(
    parameter int CNT_W = 8
);
    logic             valid_in;
    logic             pattern_in;
    logic [1:0]       sel_out;
    logic             done;
    logic             match;
    logic             err;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output valid_in, pattern_in,
        input  sel_out, done, match, err, frame_cnt
    );

    modport slave (
        input  valid_in, pattern_in,
        output sel_out, done, match, err, frame_cnt
    );
endinterface

// File: rtl/pattern_det.sv
// 4-bit serial frame detector: decodes 11xx into a 2-bit selector, flags illegal/aborted frames.
// Define PATTERN_DET_CNT_EN to build the saturating good-frame counter on frame_cnt.
module pattern_det #(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    pattern_det_if.slave  bus
);
    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic [3:0] shreg_q, shreg_d;
    logic [1:0] sel_q, sel_d;
    logic       done_q, done_d;
    logic       match_q, match_d;
    logic       err_q, err_d;
    logic [3:0] frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            shreg_q <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        match_d = 1'b0;
        err_d   = 1'b0;
        // Shift register contents as they will be once the current bit is taken.
        frame   = {shreg_q[2:0], bus.pattern_in};
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    shreg_d = frame;
                    bcnt_d  = 2'd1;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (bus.valid_in) begin
                    shreg_d = frame;
                    if (bcnt_q == 2'd3) begin
                        bcnt_d  = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                        if (frame[3:2] == 2'b11) begin
                            match_d = 1'b1;
                            sel_d   = frame[1:0];
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end else begin
                    err_d   = 1'b1;
                    shreg_d = '0;
                    bcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sel_out = sel_q;
    assign bus.done    = done_q;
    assign bus.match   = match_q;
    assign bus.err     = err_q;

`ifdef PATTERN_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // Counts alongside the registered match pulse; holds at all-ones.
        if (match_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.frame_cnt = cnt_q;
`else
    assign bus.frame_cnt = '0;
`endif
endmodule

// File: tb/tb_pattern_det.sv
// Scoreboard bench for pattern_det: stimulus pushes expected events, a negedge monitor checks them.
module tb_pattern_det;
`ifdef PATTERN_DET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic       done;
        logic       match;
        logic       err;
        logic [1:0] sel;
        int         cnt;
        int         cnt2;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vin = 1'b0;
    logic pin = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_done = 0;

    exp_t       q[$];
    logic [1:0] exp_sel  = 2'b00;
    int         exp_cnt  = 0;
    int         exp_cnt2 = 0;

    pattern_det_if #(.CNT_W(8)) bus  ();
    pattern_det_if #(.CNT_W(2)) bus2 ();

    assign bus.valid_in    = vin;
    assign bus.pattern_in  = pin;
    assign bus2.valid_in   = vin;
    assign bus2.pattern_in = pin;

    pattern_det #(.CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
    pattern_det #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done/err pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst && (bus.done || bus.err)) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got done=%b err=%b expected no event (t=%0t)",
                         bus.done, bus.err, $time);
            end else begin
                e = q.pop_front();
                chk("done", bus.done, e.done);
                chk("match", bus.match, e.match);
                chk("err", bus.err, e.err);
                chk("sel_out", bus.sel_out, e.sel);
                chk("frame_cnt", bus.frame_cnt, e.cnt);
                chk("frame_cnt_w2", bus2.frame_cnt, e.cnt2);
                chk("match_err_excl", bus.match & bus.err, 0);
                if (e.gap != 0) chk("done_gap", cyc - last_done, e.gap);
            end
            if (bus.done) last_done = cyc;
        end
    end

    task automatic idle(input int n);
        vin = 1'b0;
        pin = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic frame(input logic [3:0] b, input logic legal, input logic [1:0] sel, input int gap);
        exp_t e;
        for (int i = 3; i >= 0; i--) begin
            vin = 1'b1;
            pin = b[i];
            @(posedge clk);
            #2;
        end
        if (legal) begin
            exp_sel = sel;
            if (CNT_EN && exp_cnt < 255) exp_cnt++;
            if (CNT_EN && exp_cnt2 < 3) exp_cnt2++;
        end
        e = '{done: 1'b1, match: legal, err: !legal, sel: exp_sel,
              cnt: exp_cnt, cnt2: exp_cnt2, gap: gap};
        q.push_back(e);
    endtask

    task automatic abort_after(input logic [3:0] b, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            vin = 1'b1;
            pin = b[3-i];
            @(posedge clk);
            #2;
        end
        vin = 1'b0;
        pin = 1'b0;
        e = '{done: 1'b0, match: 1'b0, err: 1'b1, sel: exp_sel,
              cnt: exp_cnt, cnt2: exp_cnt2, gap: 0};
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_sel", bus.sel_out, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_match", bus.match, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_cnt", bus.frame_cnt, 0);
        rst = 1'b0;
        idle(2);

        frame(4'b1100, 1'b1, 2'b00, 0);
        idle(2);

        frame(4'b1100, 1'b1, 2'b00, 0);
        frame(4'b1101, 1'b1, 2'b01, 4);
        frame(4'b1110, 1'b1, 2'b10, 4);
        frame(4'b1111, 1'b1, 2'b11, 4);
        idle(2);

        frame(4'b1010, 1'b0, 2'b00, 0);
        idle(1);
        frame(4'b0000, 1'b0, 2'b00, 0);
        frame(4'b1011, 1'b0, 2'b00, 4);
        idle(2);

        abort_after(4'b1100, 2);
        frame(4'b1101, 1'b1, 2'b01, 0);
        idle(1);
        abort_after(4'b1100, 3);
        abort_after(4'b1000, 1);
        idle(2);

        // Asynchronous reset between edges with two bits of a frame held.
        vin = 1'b1;
        pin = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #1;
        rst = 1'b1;
        vin = 1'b0;
        pin = 1'b0;
        #1;
        chk("arst_sel", bus.sel_out, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_match", bus.match, 0);
        chk("arst_err", bus.err, 0);
        chk("arst_cnt", bus.frame_cnt, 0);
        chk("arst_cnt_w2", bus2.frame_cnt, 0);
        exp_sel  = 2'b00;
        exp_cnt  = 0;
        exp_cnt2 = 0;
        #4;
        rst = 1'b0;
        @(posedge clk);
        #2;
        idle(1);

        frame(4'b1110, 1'b1, 2'b10, 0);
        frame(4'b1100, 1'b1, 2'b00, 4);
        frame(4'b1111, 1'b1, 2'b11, 4);
        frame(4'b1101, 1'b1, 2'b01, 4);
        frame(4'b1110, 1'b1, 2'b10, 4);
        frame(4'b1100, 1'b1, 2'b00, 4);
        idle(4);

        chk("queue_drained", q.size(), 0);
        chk("final_cnt_w2", bus2.frame_cnt, CNT_EN ? 3 : 0);
        chk("final_cnt", bus.frame_cnt, CNT_EN ? 6 : 0);
        chk("final_sel", bus.sel_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pattern_det.md
PATTERN_DET -- requirements
Module: pattern_det

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the good-frame counter.
REQ-002 The block SHALL have port clk, input, 1, the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port valid_in, input, 1; qualifies pattern_in on each rising clk.
REQ-005 The block SHALL have port pattern_in, input, 1; serial frame bit, MSB first.
REQ-006 The block SHALL have port sel_out, output, 2; the decoded selector of the last good frame.
REQ-007 The block SHALL have port done, output, 1; a one-cycle pulse marking frame completion.
REQ-008 The block SHALL have port match, output, 1; a one-cycle pulse with done when the frame is a legal code.
REQ-009 The block SHALL have port err, output, 1; a one-cycle pulse for an illegal code or an aborted frame.
REQ-010 The block SHALL have port frame_cnt, output, CNT_W; the count of good frames.

Function
REQ-011 A frame SHALL be 4 bits, sampled on 4 consecutive rising edges with valid_in=1, shifted MSB first into a 4-bit register.
REQ-012 The decode SHALL be: 1100->sel 00, 1101->01, 1110->10, 1111->11; any other value is illegal.
REQ-013 The FSM SHALL have states IDLE and RECV and a 2-bit bit counter bcnt (0..3).
REQ-014 IDLE: on valid_in=1, sample bit 0, set bcnt=1 and go to RECV; on valid_in=0, stay in IDLE.
REQ-015 RECV: on valid_in=1 with bcnt<3, sample the bit and increment bcnt.
REQ-016 RECV: on valid_in=1 with bcnt=3, sample bit 3, set bcnt=0 and go to IDLE; next cycle done=1.
REQ-017 Latency SHALL be 1 cycle: done, match, err and sel_out are registered and update on the edge after bit 3 is sampled.
REQ-018 For a legal code: done=1, match=1, err=0, sel_out=decoded value, held until the next good frame.
REQ-019 For an illegal code: done=1, match=0, err=1, sel_out unchanged.
REQ-020 Abort: valid_in=0 in RECV (1..3 bits held) SHALL pulse err=1 with done=0 next cycle, discard the partial frame, set bcnt=0 and go to IDLE.
REQ-021 Back-to-back: valid_in=1 in the cycle in which done is high SHALL be taken as bit 0 of the next frame, with no bubble.
REQ-022 done, match and err SHALL each be high for exactly one cycle per event; match and err SHALL never be high together.

Reset
REQ-023 Asserting rst SHALL immediately force state=IDLE, bcnt=0, shift register=0, sel_out=00, done=0, match=0, err=0 and frame_cnt=0.
REQ-024 rst asserted mid-frame SHALL discard the partial frame with no err pulse; the first valid bit after release SHALL start a new frame.

Configuration
REQ-025 With macro PATTERN_DET_CNT_EN defined, frame_cnt SHALL increment by 1 on each match pulse and saturate at 2^CNT_W-1, with no wrap.
REQ-026 Without PATTERN_DET_CNT_EN, frame_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-027 rst pulse, then valid_in=1 for 4 cycles with bits 1,1,0,0 -> one cycle later done=1, match=1, sel_out=00.
REQ-028 Four back-to-back frames 1100, 1101, 1110, 1111 with valid_in held high for 16 cycles -> 4 done pulses 4 cycles apart; sel_out=00, 01, 10, 11 in turn; frame_cnt=4 with the macro defined, 0 without it.
REQ-029 Frame 1010 -> done=1, err=1, match=0, and sel_out keeps its previous value.
REQ-030 Bits 1,1 then valid_in=0 -> err=1 one cycle later with done=0; a following frame 1101 decodes correctly to 01.
REQ-031 rst asserted asynchronously between clock edges after 2 bits -> outputs go to reset values immediately; no err pulse; a following frame 1110 gives sel_out=10.
REQ-032 With CNT_W=2 and the macro defined, 5 good frames -> frame_cnt stays at 3.
